// File: rtl/ctrl_seq_unit_if.sv
// ----------------------------------------------------------------------------
// ctrl_seq_unit_if
// Instruction-memory fetch bus between the sequencer and instruction memory.
//
// Signals:
//   imem_req    sequencer -> memory  fetch request, held for the whole fetch
//   imem_addr   sequencer -> memory  fetch address, stable while imem_req=1
//   imem_rdata  memory -> sequencer  instruction word
//   imem_valid  memory -> sequencer  imem_rdata is valid in this cycle
//
// Modports:
//   master  the sequencer side (drives req/addr)
//   slave   the instruction-memory side (drives rdata/valid)
// ----------------------------------------------------------------------------
interface ctrl_seq_unit_if #(
    parameter int AW = 8,
    parameter int IW = 24
);

    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );

endinterface

// File: rtl/ctrl_seq_unit.sv
// ----------------------------------------------------------------------------
// ctrl_seq_unit
// Instruction sequencer for the 8-register ALU/branch core. Fetches a 24-bit
// instruction word at the core's instruction pointer, decodes it into the
// core's control lines and issues one commit strobe per instruction.
// Supports free-run, single-step, halt (HLT instruction) and a fetch-timeout
// fault. HALT and FAULT are sticky until reset.
//
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   run           level: fetch/execute continuously
//   step          one-cycle pulse: execute one instruction from IDLE when run=0
//   pc_in         core instruction pointer, sampled on entry to FETCH
//   imem          fetch bus (master side): req/addr out, rdata/valid in
//   mem_inst, alu_inst, jmp_inst   instruction-class lines
//   ms            regbank mode: 00 ALU, 01 REG, 10 IMM, 11 MEM
//   irs           ALU B operand select: 0 register, 1 immediate
//   rs, ar, bs    destination / A-source / B-source register selects
//   op            ALU opcode or branch condition
//   imm           immediate or branch target
//   core_step     core commits the current control vector this cycle
//   busy          sequencer is mid-instruction (FETCH/DECODE/EXEC)
//   halted        HLT instruction reached
//   fault         fetch timed out
//   inst_cnt      retired-instruction counter (wraps)
// ----------------------------------------------------------------------------
module ctrl_seq_unit #(
    parameter int IW            = 24,
    parameter int AW            = 8,
    parameter int FETCH_TIMEOUT = 15,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 step,
    input  logic [AW-1:0]        pc_in,
    ctrl_seq_unit_if.master      imem,
    output logic                 mem_inst,
    output logic                 alu_inst,
    output logic                 jmp_inst,
    output logic [1:0]           ms,
    output logic                 irs,
    output logic [2:0]           rs,
    output logic [2:0]           ar,
    output logic [2:0]           bs,
    output logic [3:0]           op,
    output logic [7:0]           imm,
    output logic                 core_step,
    output logic                 busy,
    output logic                 halted,
    output logic                 fault,
    output logic [CNT_W-1:0]     inst_cnt
);

    localparam int TW = $clog2(FETCH_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT,
        ST_FAULT
    } state_t;

    // Full control vector presented to the core.
    typedef struct packed {
        logic       mem;
        logic       alu;
        logic       jmp;
        logic [1:0] ms;
        logic       irs;
        logic [2:0] rs;
        logic [2:0] ar;
        logic [2:0] bs;
        logic [3:0] op;
        logic [7:0] imm;
    } ctrl_t;

    state_t        state;
    logic [IW-1:0] ir;
    logic [TW-1:0] tcnt;
    ctrl_t         ctrl;

    // Translates one instruction word into the core's control vector.
    // Class 00 ALU, 01 MOVR, 10 MOVI, 11 JMP/SYS; class 11 with OP=1111 is
    // HLT and drives nothing at all.
    function automatic ctrl_t decode_word(input logic [IW-1:0] w);
        ctrl_t c;
        c     = '0;
        c.op  = w[21:18];
        c.rs  = w[17:15];
        c.ar  = w[14:12];
        c.bs  = w[11:9];
        c.irs = w[8];
        c.imm = w[7:0];
        case (w[23:22])
            2'b00: begin
                c.mem = 1'b1;
                c.alu = 1'b1;
                c.ms  = 2'b00;
            end
            2'b01: begin
                c.mem = 1'b1;
                c.ms  = 2'b01;
                c.irs = 1'b0;
                c.op  = 4'b0000;
            end
            2'b10: begin
                c.mem = 1'b1;
                c.ms  = 2'b10;
                c.irs = 1'b1;
            end
            default: begin
                if (w[21:18] == 4'b1111) begin
                    c = '0;
                end else begin
                    c.jmp = 1'b1;
                    c.ms  = 2'b00;
                end
            end
        endcase
        return c;
    endfunction

    // Main sequencer: one state register plus every output registered
    // alongside it, so the core never sees decode glitches.
    // The control vector is first loaded from the fetched word as it is
    // latched into IR, so it is already valid during DECODE; it is reloaded
    // from IR on the way into EXEC and cleared when leaving EXEC.
    // The timeout counter counts FETCH cycles without imem_valid; the
    // FETCH_TIMEOUT-th such cycle moves to FAULT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            ir             <= '0;
            tcnt           <= '0;
            ctrl           <= '0;
            imem.imem_req  <= 1'b0;
            imem.imem_addr <= '0;
            core_step      <= 1'b0;
            busy           <= 1'b0;
            halted         <= 1'b0;
            fault          <= 1'b0;
            inst_cnt       <= '0;
        end else begin
            core_step <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (run || step) begin
                        state          <= ST_FETCH;
                        imem.imem_req  <= 1'b1;
                        imem.imem_addr <= pc_in;
                        tcnt           <= '0;
                        busy           <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    if (imem.imem_valid) begin
                        state         <= ST_DECODE;
                        ir            <= imem.imem_rdata;
                        ctrl          <= decode_word(imem.imem_rdata);
                        tcnt          <= '0;
                        imem.imem_req <= 1'b0;
                    end else if (tcnt == TW'(FETCH_TIMEOUT - 1)) begin
                        state         <= ST_FAULT;
                        tcnt          <= '0;
                        imem.imem_req <= 1'b0;
                        busy          <= 1'b0;
                        fault         <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                ST_DECODE: begin
                    if (ir[23:22] == 2'b11 && ir[21:18] == 4'b1111) begin
                        state  <= ST_HALT;
                        ctrl   <= '0;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        state     <= ST_EXEC;
                        ctrl      <= decode_word(ir);
                        core_step <= 1'b1;
                        inst_cnt  <= inst_cnt + CNT_W'(1);
                    end
                end

                ST_EXEC: begin
                    ctrl <= '0;
                    if (run) begin
                        state          <= ST_FETCH;
                        imem.imem_req  <= 1'b1;
                        imem.imem_addr <= pc_in;
                        tcnt           <= '0;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                ST_HALT, ST_FAULT: begin
                    state <= state;
                end

                default: begin
                    state         <= ST_IDLE;
                    ctrl          <= '0;
                    imem.imem_req <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

    // Control lines come straight from the registered control vector.
    assign mem_inst = ctrl.mem;
    assign alu_inst = ctrl.alu;
    assign jmp_inst = ctrl.jmp;
    assign ms       = ctrl.ms;
    assign irs      = ctrl.irs;
    assign rs       = ctrl.rs;
    assign ar       = ctrl.ar;
    assign bs       = ctrl.bs;
    assign op       = ctrl.op;
    assign imm      = ctrl.imm;

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// ----------------------------------------------------------------------------
// tb_ctrl_seq_unit
// Self-checking bench for ctrl_seq_unit. An instruction-memory responder
// answers fetches after a chosen delay; expected control vectors come from a
// field-arithmetic model of the instruction set, and expected timing from the
// rule "an instruction costs (fetch delay + 3) cycles".
// ----------------------------------------------------------------------------
module tb_ctrl_seq_unit;

    localparam int IW            = 24;
    localparam int AW            = 8;
    localparam int FETCH_TIMEOUT = 15;
    localparam int CNT_W         = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic             step;
    logic [AW-1:0]    pc_in;
    logic             mem_inst, alu_inst, jmp_inst;
    logic [1:0]       ms;
    logic             irs;
    logic [2:0]       rs, ar, bs;
    logic [3:0]       op;
    logic [7:0]       imm;
    logic             core_step, busy, halted, fault;
    logic [CNT_W-1:0] inst_cnt;

    ctrl_seq_unit_if #(.AW(AW), .IW(IW)) bus ();

    ctrl_seq_unit #(
        .IW(IW), .AW(AW), .FETCH_TIMEOUT(FETCH_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .pc_in(pc_in),
        .imem(bus),
        .mem_inst(mem_inst), .alu_inst(alu_inst), .jmp_inst(jmp_inst),
        .ms(ms), .irs(irs), .rs(rs), .ar(ar), .bs(bs), .op(op), .imm(imm),
        .core_step(core_step), .busy(busy), .halted(halted), .fault(fault),
        .inst_cnt(inst_cnt)
    );

    always #5 clk = ~clk;

    int            checkCount = 0;
    int            passCount  = 0;
    int            cycle      = 0;
    int            reqRun     = 0;
    int            fetchDelay = 0;
    bit            memEnable  = 1'b1;
    bit            randDelay  = 1'b0;
    bit            noise      = 1'b0;
    logic [AW-1:0] lastPc;
    logic [IW-1:0] imem [256];

    // Reference instruction-set model: pulls fields apart arithmetically and
    // applies the class rules of the instruction set.
    function automatic logic [26:0] ref_ctrl(input logic [23:0] w);
        int x, cls, opc, rsf, arf, bsf, irsf, immf;
        int memv, aluv, jmpv, msv, irsv, opv;
        x    = int'(w);
        cls  = x >> 22;
        opc  = (x >> 18) % 16;
        rsf  = (x >> 15) % 8;
        arf  = (x >> 12) % 8;
        bsf  = (x >> 9) % 8;
        irsf = (x >> 8) % 2;
        immf = x % 256;
        if (cls == 3 && opc == 15) return '0;
        memv = (cls != 3) ? 1 : 0;
        aluv = (cls == 0) ? 1 : 0;
        jmpv = (cls == 3) ? 1 : 0;
        msv  = (cls == 3) ? 0 : cls;
        irsv = (cls == 1) ? 0 : (cls == 2) ? 1 : irsf;
        opv  = (cls == 1) ? 0 : opc;
        return {1'(memv), 1'(aluv), 1'(jmpv), 2'(msv), 1'(irsv), 3'(rsf),
                3'(arf), 3'(bsf), 4'(opv), 8'(immf)};
    endfunction

    function automatic logic [26:0] observed_ctrl();
        return {mem_inst, alu_inst, jmp_inst, ms, irs, rs, ar, bs, op, imm};
    endfunction

    function automatic logic [23:0] rand_word();
        logic [23:0] w;
        w = 24'($urandom);
        if (w[23:18] == 6'h3F) w[18] = 1'b0;
        return w;
    endfunction

    // Advance to the next falling edge and act as instruction memory for the
    // coming rising edge.
    task automatic tick();
        lastPc = pc_in;
        @(negedge clk);
        cycle++;
        if (bus.imem_req) begin
            if (reqRun == 0 && randDelay) fetchDelay = $urandom_range(0, 4);
            if (memEnable && reqRun == fetchDelay) begin
                bus.imem_valid = 1'b1;
                bus.imem_rdata = imem[bus.imem_addr];
            end else begin
                bus.imem_valid = 1'b0;
                bus.imem_rdata = IW'($urandom);
            end
            reqRun++;
        end else begin
            reqRun = 0;
            bus.imem_valid = noise ? 1'($urandom) : 1'b0;
            bus.imem_rdata = IW'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; step = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) imem[i] = rand_word();
    endtask

    task automatic test_reset();
        logic [63:0] allOut;
        run = 1'b1; step = 1'b0; rst = 1'b1; pc_in = 8'hA5;
        tick(); tick();
        allOut = {bus.imem_req, bus.imem_addr, observed_ctrl(), core_step,
                  busy, halted, fault, inst_cnt};
        checkCount++;
        if (allOut !== '0) $display("[TB] FAIL reset_outputs: got %h expected 0", allOut);
        else passCount++;
        checkCount++;
        if (bus.imem_req !== 1'b0) $display("[TB] FAIL reset_req: got %b expected 0", bus.imem_req);
        else passCount++;
        checkCount++;
        if (inst_cnt !== '0) $display("[TB] FAIL reset_cnt: got %0d expected 0", inst_cnt);
        else passCount++;
        run = 1'b0; rst = 1'b0;
        tick(); tick();
        checkCount++;
        if ({busy, bus.imem_req} !== 2'b00) $display("[TB] FAIL reset_idle: got %b expected 00", {busy, bus.imem_req});
        else passCount++;
    endtask

    task automatic test_single_step();
        int stepsSeen = 0;
        int firstAt   = 0;
        do_reset();
        randDelay = 1'b0; fetchDelay = 0; noise = 1'b0; memEnable = 1'b1;
        pc_in = 8'd0; imem[0] = 24'h9C0105;
        step = 1'b1;
        tick();
        step = 1'b0;
        checkCount++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'd0})
            $display("[TB] FAIL step_fetch: got req=%b addr=%h expected req=1 addr=00", bus.imem_req, bus.imem_addr);
        else passCount++;
        for (int k = 2; k <= 8; k++) begin
            tick();
            if (k == 2) begin
                checkCount++;
                if (observed_ctrl() !== ref_ctrl(24'h9C0105))
                    $display("[TB] FAIL step_decode: got %h expected %h", observed_ctrl(), ref_ctrl(24'h9C0105));
                else passCount++;
                checkCount++;
                if ({mem_inst, alu_inst, ms, irs, rs, imm, op} !== {1'b1, 1'b0, 2'b10, 1'b1, 3'd0, 8'd5, 4'b0111})
                    $display("[TB] FAIL step_movi_fields: got %h expected movi r0,#5 op 7", {mem_inst, alu_inst, ms, irs, rs, imm, op});
                else passCount++;
            end
            if (core_step) begin
                stepsSeen++;
                if (firstAt == 0) firstAt = k;
                checkCount++;
                if (observed_ctrl() !== ref_ctrl(24'h9C0105))
                    $display("[TB] FAIL step_exec: got %h expected %h", observed_ctrl(), ref_ctrl(24'h9C0105));
                else passCount++;
            end
        end
        checkCount++;
        if (firstAt != 3) $display("[TB] FAIL step_latency: got %0d expected 3", firstAt);
        else passCount++;
        checkCount++;
        if (stepsSeen != 1) $display("[TB] FAIL step_count: got %0d expected 1", stepsSeen);
        else passCount++;
        checkCount++;
        if (inst_cnt !== 16'd1) $display("[TB] FAIL step_inst_cnt: got %0d expected 1", inst_cnt);
        else passCount++;
        checkCount++;
        if ({busy, halted, fault, bus.imem_req, observed_ctrl()} !== '0)
            $display("[TB] FAIL step_back_idle: got busy=%b req=%b ctrl=%h expected all 0", busy, bus.imem_req, observed_ctrl());
        else passCount++;
    endtask

    task automatic test_run_sequence();
        int steps = 0;
        int stepCycle [2];
        int stray = 0;
        do_reset();
        imem[0] = 24'h000200; imem[1] = 24'hE0003F; imem[2] = 24'hFC0000;
        randDelay = 1'b0; fetchDelay = 2; pc_in = 8'd0; run = 1'b1;
        for (int k = 0; k < 60 && !halted; k++) begin
            tick();
            if (bus.imem_req && reqRun == 1) begin
                checkCount++;
                if (bus.imem_addr !== pc_in) $display("[TB] FAIL seq_addr: got %h expected %h", bus.imem_addr, pc_in);
                else passCount++;
            end
            if (core_step) begin
                checkCount++;
                if (steps > 2 || observed_ctrl() !== ref_ctrl(imem[steps % 3]))
                    $display("[TB] FAIL seq_ctrl: got %h expected %h (step %0d)", observed_ctrl(), ref_ctrl(imem[steps % 3]), steps);
                else passCount++;
                if (steps == 0) begin
                    checkCount++;
                    if ({alu_inst, ms, bs} !== {1'b1, 2'b00, 3'd1}) $display("[TB] FAIL seq_add: got %b expected 1_00_001", {alu_inst, ms, bs});
                    else passCount++;
                end
                if (steps == 1) begin
                    checkCount++;
                    if ({jmp_inst, mem_inst, op, imm} !== {1'b1, 1'b0, 4'b1000, 8'd63})
                        $display("[TB] FAIL seq_jc: got %h expected jmp=1 mem=0 op=8 imm=63", {jmp_inst, mem_inst, op, imm});
                    else passCount++;
                end
                if (steps < 2) stepCycle[steps] = cycle;
                steps++;
                pc_in = AW'(steps);
            end
        end
        checkCount++;
        if (halted !== 1'b1 || steps != 2) $display("[TB] FAIL seq_halt: got halted=%b steps=%0d expected halted=1 steps=2", halted, steps);
        else passCount++;
        checkCount++;
        if (steps == 2 && stepCycle[1] - stepCycle[0] != 5)
            $display("[TB] FAIL seq_rate: got gap %0d expected 5", stepCycle[1] - stepCycle[0]);
        else passCount++;
        for (int k = 0; k < 12; k++) begin
            run = 1'($urandom); step = 1'($urandom);
            tick();
            if (bus.imem_req || core_step || busy) stray++;
        end
        run = 1'b0; step = 1'b0;
        checkCount++;
        if (stray != 0 || halted !== 1'b1 || inst_cnt !== 16'd2 || observed_ctrl() !== '0)
            $display("[TB] FAIL halt_sticky: got stray=%0d halted=%b cnt=%0d expected 0 1 2", stray, halted, inst_cnt);
        else passCount++;
    endtask

    task automatic test_timeout();
        int reqCycles = 0;
        int steps     = 0;
        do_reset();
        memEnable = 1'b0; noise = 1'b0; run = 1'b1; pc_in = 8'h40;
        for (int k = 0; k < 60 && !fault; k++) begin
            tick();
            if (bus.imem_req) reqCycles++;
            if (core_step) steps++;
        end
        checkCount++;
        if (fault !== 1'b1) $display("[TB] FAIL timeout_fault: got %b expected 1", fault);
        else passCount++;
        checkCount++;
        if (reqCycles != FETCH_TIMEOUT) $display("[TB] FAIL timeout_cycles: got %0d expected %0d", reqCycles, FETCH_TIMEOUT);
        else passCount++;
        checkCount++;
        if ({bus.imem_req, busy, halted} !== 3'b000 || steps != 0)
            $display("[TB] FAIL timeout_quiet: got req=%b busy=%b steps=%0d expected 0 0 0", bus.imem_req, busy, steps);
        else passCount++;
        memEnable = 1'b1;
        run = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step = ~step;
            tick();
        end
        step = 1'b0;
        checkCount++;
        if (fault !== 1'b1 || bus.imem_req !== 1'b0) $display("[TB] FAIL fault_sticky: got fault=%b req=%b expected 1 0", fault, bus.imem_req);
        else passCount++;
    endtask

    task automatic test_reset_mid_exec();
        bit found = 1'b0;
        logic [63:0] allOut;
        do_reset();
        fill_random();
        memEnable = 1'b1; randDelay = 1'b0; fetchDelay = $urandom_range(0, 3);
        pc_in = AW'($urandom); run = 1'b1;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (core_step) found = 1'b1;
        end
        checkCount++;
        if (!found) $display("[TB] FAIL mid_exec_reached: got 0 expected 1");
        else passCount++;
        rst = 1'b1;
        tick();
        allOut = {bus.imem_req, bus.imem_addr, observed_ctrl(), core_step,
                  busy, halted, fault, inst_cnt};
        checkCount++;
        if (allOut !== '0) $display("[TB] FAIL mid_exec_reset: got %h expected 0", allOut);
        else passCount++;
        rst = 1'b0; run = 1'b0;
        tick();
    endtask

    task automatic test_run_drop();
        int  steps     = 0;
        int  extraReq  = 0;
        bit  sawDecode = 1'b0;
        bit  prevReq   = 1'b0;
        do_reset();
        fill_random();
        randDelay = 1'b0; fetchDelay = 1; pc_in = AW'($urandom); run = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            step = 1'b0;
            if (steps > 0 && bus.imem_req) extraReq++;
            if (bus.imem_req && reqRun == 1) step = 1'b1;
            if (!sawDecode && prevReq && !bus.imem_req && !core_step) begin
                run = 1'b0;
                sawDecode = 1'b1;
            end
            if (core_step) begin
                steps++;
                step = 1'b1;
            end
            prevReq = bus.imem_req;
        end
        step = 1'b0;
        checkCount++;
        if (!sawDecode || steps != 1) $display("[TB] FAIL drop_one_step: got decode=%0d steps=%0d expected 1 1", sawDecode, steps);
        else passCount++;
        checkCount++;
        if (extraReq != 0) $display("[TB] FAIL drop_no_refetch: got %0d expected 0", extraReq);
        else passCount++;
        checkCount++;
        if (busy !== 1'b0 || inst_cnt !== 16'd1) $display("[TB] FAIL drop_idle: got busy=%b cnt=%0d expected 0 1", busy, inst_cnt);
        else passCount++;
    endtask

    task automatic test_random_stream();
        logic [26:0]   expQ [$];
        int            delayQ [$];
        logic [AW-1:0] curAddr = '0;
        int            lastStep = -1;
        int            steps    = 0;
        int            d;
        logic [26:0]   e;
        do_reset();
        fill_random();
        memEnable = 1'b1; randDelay = 1'b1; noise = 1'b1; run = 1'b1;
        for (int k = 0; k < 500 && !(k > 400 && !busy); k++) begin
            if (k >= 400) run = 1'b0;
            pc_in = AW'($urandom);
            tick();
            if (bus.imem_req && reqRun == 1) begin
                checkCount++;
                if (bus.imem_addr !== lastPc) $display("[TB] FAIL rnd_addr: got %h expected %h", bus.imem_addr, lastPc);
                else passCount++;
                curAddr = bus.imem_addr;
                expQ.push_back(ref_ctrl(imem[bus.imem_addr]));
                delayQ.push_back(fetchDelay);
            end else if (bus.imem_req) begin
                checkCount++;
                if (bus.imem_addr !== curAddr) $display("[TB] FAIL rnd_addr_hold: got %h expected %h", bus.imem_addr, curAddr);
                else passCount++;
            end
            if (bus.imem_req) begin
                checkCount++;
                if (observed_ctrl() !== '0) $display("[TB] FAIL rnd_ctrl_idle: got %h expected 0", observed_ctrl());
                else passCount++;
            end
            if (core_step) begin
                e = (expQ.size() > 0) ? expQ.pop_front() : 27'h7FFFFFF;
                d = (delayQ.size() > 0) ? delayQ.pop_front() : -10;
                checkCount++;
                if (observed_ctrl() !== e) $display("[TB] FAIL rnd_ctrl: got %h expected %h", observed_ctrl(), e);
                else passCount++;
                if (lastStep >= 0) begin
                    checkCount++;
                    if (cycle - lastStep != d + 3) $display("[TB] FAIL rnd_rate: got %0d expected %0d", cycle - lastStep, d + 3);
                    else passCount++;
                end
                lastStep = cycle;
                steps++;
            end
        end
        noise = 1'b0; randDelay = 1'b0;
        checkCount++;
        if (inst_cnt !== CNT_W'(steps) || steps < 50)
            $display("[TB] FAIL rnd_inst_cnt: got %0d expected %0d", inst_cnt, steps);
        else passCount++;
        checkCount++;
        if ({busy, fault, halted} !== 3'b000 || expQ.size() != 0)
            $display("[TB] FAIL rnd_final: got busy=%b fault=%b pending=%0d expected 0 0 0", busy, fault, expQ.size());
        else passCount++;
    endtask

    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        rst = 1'b1; run = 1'b0; step = 1'b0; pc_in = '0;
        test_reset();
        test_single_step();
        test_run_sequence();
        test_timeout();
        test_reset_mid_exec();
        test_run_drop();
        test_random_stream();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ctrl_seq_unit.md
Name: ctrl_seq_unit

Overview:
Instruction sequencer for the 8-register ALU/branch core. It takes the core's instruction pointer and fetches a 24-bit instruction word from instruction memory over a req/valid handshake. It decodes the word into the core's control lines (MEM_INST, ALU_INST, JMP_INST, MS, IRS, RS, AR, BS, OP, IMM) and issues exactly one commit strobe per instruction. This replaces hand-driven control vectors and supports free-run, single-step, halt and fetch-timeout fault.

Parameters:
IW, 24, instruction word width (field layout below is fixed to 24)
AW, 8, instruction address width (matches core Addr)
FETCH_TIMEOUT, 15, max cycles in FETCH without IMEM_VALID before FAULT
CNT_W, 16, retired-instruction counter width

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset; synchronous, active-high
RUN  in  1  level; 1 = fetch/execute continuously
STEP  in  1  one-cycle pulse; executes one instruction when RUN=0 and state=IDLE
PC_IN  in  AW  core instruction pointer (core Addr)
IMEM_REQ  out  1  fetch request
IMEM_ADDR  out  AW  fetch address
IMEM_RDATA  in  IW  instruction word
IMEM_VALID  in  1  IMEM_RDATA valid this cycle
MEM_INST, ALU_INST, JMP_INST  out  1 each  core instruction-class lines
MS  out  2  regbank mode: 00 ALU, 01 REG, 10 IMM, 11 MEM
IRS  out  1  ALU B operand: 0 reg, 1 immediate
RS, AR, BS  out  3 each  dest / A-source / B-source register selects
OP  out  4  ALU opcode or branch condition
IMM  out  8  immediate / branch target
CORE_STEP  out  1  core commits the current control vector in this cycle
BUSY  out  1  state not IDLE/HALT/FAULT
HALTED  out  1  state = HALT
FAULT  out  1  state = FAULT
INST_CNT  out  CNT_W  retired instructions

Behaviour:
- Word layout: [23:22] class (00 ALU, 01 MOVR, 10 MOVI, 11 JMP/SYS), [21:18] OP, [17:15] RS, [14:12] AR, [11:9] BS, [8] IRS, [7:0] IMM. Class 11 with OP=1111 is HLT; other class-11 OP values are branch conditions passed through.
- Reset: state IDLE. All outputs 0: IMEM_REQ, IMEM_ADDR, all control lines, CORE_STEP, BUSY, HALTED, FAULT, INST_CNT. IR is cleared. Reset overrides every state, including mid-fetch and EXEC; IMEM_REQ is 0 in the cycle after the reset edge.
- States: IDLE, FETCH, DECODE, EXEC, HALT, FAULT.
- IDLE: if RUN=1 or STEP=1, go to FETCH. IMEM_ADDR captures PC_IN on entry and holds through FETCH.
- FETCH: IMEM_REQ=1. When IMEM_VALID=1, latch IR<=IMEM_RDATA, clear the timeout counter and go to DECODE (IMEM_REQ=0 the next cycle). Otherwise the timeout counter increments. When it reaches FETCH_TIMEOUT, go to FAULT.
- DECODE: control outputs register from IR. Next state is HALT if HLT, else EXEC.
- EXEC: CORE_STEP=1 for exactly this one cycle; control outputs unchanged from DECODE. INST_CNT increments, wrapping at 2^CNT_W. Next state is FETCH if RUN=1, else IDLE.
- Latency: with IMEM_VALID in the first FETCH cycle, one instruction takes 3 cycles (FETCH, DECODE, EXEC). Sustained run rate is 1 instruction per 3 cycles.
- Decode table (control lines valid in DECODE and EXEC only; all 0 in every other state):
  - ALU: MEM=1, ALU=1, JMP=0, MS=00; IRS, RS, AR, BS, OP, IMM from fields.
  - MOVR: MEM=1, ALU=0, JMP=0, MS=01, IRS=0, OP=0000; RS, AR, BS, IMM from fields.
  - MOVI: MEM=1, ALU=0, JMP=0, MS=10, IRS=1; RS, AR, BS, OP, IMM from fields.
  - JMP: MEM=0, ALU=0, JMP=1, MS=00; OP=condition, IMM=target; RS, AR, BS, IRS from fields.
  - HLT: all control lines 0; CORE_STEP never asserts.
- HALT and FAULT are sticky until RST. RUN and STEP are ignored there, and IMEM_REQ=0.
- STEP is ignored unless state=IDLE and RUN=0. RUN falling mid-instruction: the current instruction completes, then the block goes to IDLE.
- IMEM_VALID outside FETCH is ignored. PC_IN is sampled only on entry to FETCH.

Test Plan:
- Reset: hold RST 2 cycles with RUN=1 -> all outputs 0, state IDLE, INST_CNT=0.
- Single-step MOVI R0,#5: PC_IN=0, STEP pulse, IMEM_RDATA=0x9C0105 with VALID in the first FETCH cycle -> DECODE/EXEC show MEM=1, ALU=0, MS=10, IRS=1, RS=0, IMM=5, OP=0111; CORE_STEP=1 in exactly one cycle, 3 cycles after the STEP edge; INST_CNT=1; state returns to IDLE.
- Run sequence ADD R0,R0,R1 (0x000200), then JC #63 (0xE0003F), then HLT (0xFC0000), with VALID delayed 2 cycles each:
  - ADD gives ALU=1, MS=00, BS=1.
  - JC gives JMP=1, MEM=0, OP=1000, IMM=63.
  - HLT gives HALTED=1 and no third CORE_STEP; INST_CNT=2.
  - RUN/STEP are then ignored until RST.
- Fetch timeout: RUN=1, IMEM_VALID held 0 -> FAULT=1 after 15 FETCH cycles, IMEM_REQ=0, no CORE_STEP.
- Reset mid-EXEC: assert RST in an EXEC cycle -> next cycle all outputs 0; INST_CNT=0.
- STEP pulse while BUSY=1 (RUN=1) -> ignored. RUN drops during DECODE -> that instruction completes with 1 CORE_STEP, then the block goes to IDLE with no new IMEM_REQ.
